// File: rtl/segment_quad_accum_if.sv
// ---------------------------------------------------------------------------
// segment_quad_accum_if
// Pixel-stream and result bundle for segment_quad_accum.
//   master : pixel source / configuration side (drives pix_en, hcnt, vcnt,
//            pixel_in, chan_sel, thresh; receives pixel_out and results)
//   slave  : the accumulator itself
// Signals:
//   pix_en, hcnt[9:0], vcnt[9:0], pixel_in[11:0]  pixel stream
//   chan_sel[1:0], thresh[4*ACC_W-1:0]            configuration
//   pixel_out[11:0]                               window-masked pixel
//   quad_bits, quad_count, result_valid, busy     per-digit results
// ---------------------------------------------------------------------------
interface segment_quad_accum_if #(
    parameter int NUM_DIGITS = 6,
    parameter int ACC_W      = 16
);
    logic                      pix_en;
    logic [9:0]                hcnt;
    logic [9:0]                vcnt;
    logic [11:0]               pixel_in;
    logic [1:0]                chan_sel;
    logic [4*ACC_W-1:0]        thresh;
    logic [11:0]               pixel_out;
    logic [4*NUM_DIGITS-1:0]   quad_bits;
    logic [3*NUM_DIGITS-1:0]   quad_count;
    logic                      result_valid;
    logic                      busy;

    modport master (
        output pix_en, hcnt, vcnt, pixel_in, chan_sel, thresh,
        input  pixel_out, quad_bits, quad_count, result_valid, busy
    );

    modport slave (
        input  pix_en, hcnt, vcnt, pixel_in, chan_sel, thresh,
        output pixel_out, quad_bits, quad_count, result_valid, busy
    );
endinterface

// File: rtl/segment_quad_accum.sv
// ---------------------------------------------------------------------------
// segment_quad_accum
// Per-digit quadrant accumulator. Each of NUM_DIGITS windows is split into
// UL/UR/LL/LR quadrants; one colour channel of the pixel stream is summed per
// quadrant over a frame, then every quadrant is compared against a shared
// threshold set, one digit per clock, producing quad_bits and quad_count.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    segment_quad_accum_if.slave (pixel stream, config, results)
// ---------------------------------------------------------------------------
module segment_quad_accum #(
    parameter int NUM_DIGITS = 6,
    parameter int X0         = 50,
    parameter int DIG_W      = 74,
    parameter int PITCH      = 90,
    parameter int Y0         = 150,
    parameter int DIG_H      = 150,
    parameter int EVAL_LINE  = 310,
    parameter int ACC_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    segment_quad_accum_if.slave  bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HALF_W = DIG_W / 2;
    localparam int HALF_H = DIG_H / 2;

    typedef enum logic [1:0] {S_HOLD, S_ACCUM, S_EVAL} state_t;

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q [NUM_DIGITS][4];
    logic [ACC_W-1:0]        acc_d [NUM_DIGITS][4];
    logic [ACC_W-1:0]        thr_q [4];
    logic [ACC_W-1:0]        thr_d [4];
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] quad_bits_q, quad_bits_d;
    logic [3*NUM_DIGITS-1:0] quad_count_q, quad_count_d;
    logic                    result_valid_q, result_valid_d;
    logic [11:0]             pixel_out_q, pixel_out_d;

    int                      h_pos, v_pos;
    logic [5:0]              chan_val;
    logic                    in_win;
    logic                    frame_start, eval_start;
    logic [3:0]              eval_bits;

    // Selected channel, zero-extended to 6 bits; 3 sums all three nibbles.
    function automatic logic [5:0] chan_value(input logic [11:0] pix, input logic [1:0] sel);
        logic [5:0] r, g, b;
        r = {2'b00, pix[11:8]};
        g = {2'b00, pix[7:4]};
        b = {2'b00, pix[3:0]};
        case (sel)
            2'd0:    return r;
            2'd1:    return g;
            2'd2:    return b;
            default: return r + g + b;
        endcase
    endfunction

    // Saturating add: clamps at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [5:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-5){1'b0}}, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] b);
        return 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
    endfunction

    assign h_pos       = int'(bus.hcnt);
    assign v_pos       = int'(bus.vcnt);
    assign chan_val    = chan_value(bus.pixel_in, bus.chan_sel);
    assign frame_start = bus.pix_en && (bus.vcnt == 10'd0) && (bus.hcnt == 10'd0);
    assign eval_start  = bus.pix_en && (bus.vcnt == 10'(EVAL_LINE)) && (bus.hcnt == 10'd0);

    // Window membership for the pixel output mask (any digit).
    always_comb begin
        in_win = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (h_pos > X0 + d*PITCH && h_pos <= X0 + d*PITCH + DIG_W &&
                v_pos > Y0 && v_pos <= Y0 + DIG_H)
                in_win = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        thr_d          = thr_q;
        idx_d          = idx_q;
        quad_bits_d    = quad_bits_q;
        quad_count_d   = quad_count_q;
        result_valid_d = 1'b0;
        pixel_out_d    = pixel_out_q;
        eval_bits      = 4'b0000;

        if (bus.pix_en)
            pixel_out_d = in_win ? bus.pixel_in : 12'h000;

        case (state_q)
            S_HOLD: begin
                if (frame_start) begin
                    state_d = S_ACCUM;
                    for (int d = 0; d < NUM_DIGITS; d++)
                        for (int q = 0; q < 4; q++)
                            acc_d[d][q] = '0;
                end
            end

            S_ACCUM: begin
                // Quadrant q: bit 0 selects the right half, bit 1 the bottom half.
                if (bus.pix_en) begin
                    for (int d = 0; d < NUM_DIGITS; d++)
                        for (int q = 0; q < 4; q++)
                            if (h_pos >  X0 + d*PITCH + (q % 2)*HALF_W &&
                                h_pos <= X0 + d*PITCH + (q % 2 + 1)*HALF_W &&
                                v_pos >  Y0 + (q / 2)*HALF_H &&
                                v_pos <= Y0 + (q / 2 + 1)*HALF_H)
                                acc_d[d][q] = sat_add(acc_q[d][q], chan_val);
                end
                if (eval_start) begin
                    state_d = S_EVAL;
                    idx_d   = '0;
                    for (int q = 0; q < 4; q++)
                        thr_d[q] = bus.thresh[q*ACC_W +: ACC_W];
                end
            end

            S_EVAL: begin
                // One digit per clock; frame starts seen here are ignored.
                for (int q = 0; q < 4; q++)
                    eval_bits[q] = acc_q[idx_q][q] > thr_q[q];
                quad_bits_d[4*idx_q +: 4]  = eval_bits;
                quad_count_d[3*idx_q +: 3] = popcount4(eval_bits);
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    state_d        = S_HOLD;
                    idx_d          = '0;
                    result_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_HOLD;
            idx_q          <= '0;
            quad_bits_q    <= '0;
            quad_count_q   <= '0;
            result_valid_q <= 1'b0;
            pixel_out_q    <= 12'h000;
            for (int d = 0; d < NUM_DIGITS; d++)
                for (int q = 0; q < 4; q++)
                    acc_q[d][q] <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            quad_bits_q    <= quad_bits_d;
            quad_count_q   <= quad_count_d;
            result_valid_q <= result_valid_d;
            pixel_out_q    <= pixel_out_d;
            acc_q          <= acc_d;
        end
    end

    // Threshold snapshot is only consumed in S_EVAL after being loaded.
    always_ff @(posedge clk) begin
        thr_q <= thr_d;
    end

    assign bus.pixel_out    = pixel_out_q;
    assign bus.quad_bits    = quad_bits_q;
    assign bus.quad_count   = quad_count_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q == S_EVAL);

endmodule

// File: tb/tb_segment_quad_accum.sv
// ---------------------------------------------------------------------------
// tb_segment_quad_accum
// Bench for segment_quad_accum using a reduced geometry so a whole frame is a
// few hundred pixels. Two instances share the stimulus: one with a wide
// accumulator and one with an 8-bit accumulator for saturation.
// ---------------------------------------------------------------------------
module tb_segment_quad_accum;

    localparam int ND    = 3;
    localparam int X0    = 4;
    localparam int DW    = 8;
    localparam int PITCH = 10;
    localparam int Y0    = 3;
    localparam int DH    = 6;
    localparam int EVL   = 12;
    localparam int WA    = 16;
    localparam int WB    = 8;
    localparam int HMAX  = 39;
    localparam int VMAX  = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    segment_quad_accum_if #(.NUM_DIGITS(ND), .ACC_W(WA)) ifa ();
    segment_quad_accum_if #(.NUM_DIGITS(ND), .ACC_W(WB)) ifb ();

    segment_quad_accum #(
        .NUM_DIGITS(ND), .X0(X0), .DIG_W(DW), .PITCH(PITCH), .Y0(Y0),
        .DIG_H(DH), .EVAL_LINE(EVL), .ACC_W(WA)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    segment_quad_accum #(
        .NUM_DIGITS(ND), .X0(X0), .DIG_W(DW), .PITCH(PITCH), .Y0(Y0),
        .DIG_H(DH), .EVAL_LINE(EVL), .ACC_W(WB)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int rv_a = 0, rv_b = 0, busy_a = 0;

    // Reference model state
    int          sum [ND][4];
    int          thr_a [4];
    int          thr_b [4];
    int          pix_bad;
    logic [11:0] exp_pix;

    always @(negedge clk) begin
        if (ifa.result_valid) rv_a++;
        if (ifb.result_valid) rv_b++;
        if (ifa.busy)         busy_a++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic int chval(input logic [11:0] p, input logic [1:0] s);
        case (s)
            2'd0:    return int'(p[11:8]);
            2'd1:    return int'(p[7:4]);
            2'd2:    return int'(p[3:0]);
            default: return int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0]);
        endcase
    endfunction

    // Quadrant of digit d hit by (h,v): 0=UL 1=UR 2=LL 3=LR, -1 outside.
    function automatic int quad_of(input int d, input int h, input int v);
        int l;
        l = X0 + d*PITCH;
        if (h <= l || h > l + DW || v <= Y0 || v > Y0 + DH) return -1;
        return ((h > l + DW/2) ? 1 : 0) + ((v > Y0 + DH/2) ? 2 : 0);
    endfunction

    function automatic bit in_any(input int h, input int v);
        for (int d = 0; d < ND; d++)
            if (quad_of(d, h, v) >= 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4*ND-1:0] exp_bits(input int w, input int th [4]);
        logic [4*ND-1:0] r;
        int maxv, a;
        maxv = (1 << w) - 1;
        r = '0;
        for (int d = 0; d < ND; d++)
            for (int q = 0; q < 4; q++) begin
                a = (sum[d][q] > maxv) ? maxv : sum[d][q];
                r[4*d+q] = (a > th[q]);
            end
        return r;
    endfunction

    function automatic logic [3*ND-1:0] exp_count(input logic [4*ND-1:0] b);
        logic [3*ND-1:0] r;
        int n;
        r = '0;
        for (int d = 0; d < ND; d++) begin
            n = 0;
            for (int q = 0; q < 4; q++) n += int'(b[4*d+q]);
            r[3*d +: 3] = 3'(n);
        end
        return r;
    endfunction

    task automatic drive(input bit en, input int h, input int v, input logic [11:0] p);
        ifa.pix_en = en;  ifa.hcnt = 10'(h);  ifa.vcnt = 10'(v);  ifa.pixel_in = p;
        ifb.pix_en = en;  ifb.hcnt = 10'(h);  ifb.vcnt = 10'(v);  ifb.pixel_in = p;
    endtask

    task automatic set_thr();
        for (int q = 0; q < 4; q++) begin
            ifa.thresh[q*WA +: WA] = WA'(thr_a[q]);
            ifb.thresh[q*WB +: WB] = WB'(thr_b[q]);
        end
    endtask

    // mode 0: random pixels, 1: constant cpix, 2: cpix only at digit-0 M edge, top line
    task automatic run_frame(input int mode, input logic [11:0] cpix, input logic [1:0] sel,
                             input bit toggle, input int rst_line, input bit scramble);
        logic [11:0] p;
        int q;
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < 4; k++) sum[d][k] = 0;
        pix_bad = 0;
        ifa.chan_sel = sel;
        ifb.chan_sel = sel;
        set_thr();
        for (int v = 0; v <= VMAX; v++) begin
            for (int h = 0; h <= HMAX; h++) begin
                case (mode)
                    0:       p = 12'($urandom);
                    1:       p = cpix;
                    default: p = (h == X0 + DW/2 && v == Y0 + 1) ? cpix : 12'h000;
                endcase
                for (int d = 0; d < ND; d++) begin
                    q = quad_of(d, h, v);
                    if (q >= 0) sum[d][q] += chval(p, sel);
                end
                drive(1'b1, h, v, p);
                if (v == rst_line && h == 0) rst_n = 1'b0;
                if (scramble && v == EVL && h == 1) begin
                    ifa.thresh = ~ifa.thresh;
                    ifb.thresh = ~ifb.thresh;
                end
                @(posedge clk); #1;
                exp_pix = (rst_n == 1'b0) ? 12'h000 : (in_any(h, v) ? p : 12'h000);
                rst_n = 1'b1;
                if (ifa.pixel_out !== exp_pix || ifb.pixel_out !== exp_pix) pix_bad++;
                if (toggle) begin
                    drive(1'b0, int'($urandom_range(0, HMAX)), int'($urandom_range(0, VMAX)),
                          12'($urandom));
                    @(posedge clk); #1;
                    if (ifa.pixel_out !== exp_pix || ifb.pixel_out !== exp_pix) pix_bad++;
                end
            end
        end
        drive(1'b0, 0, 0, 12'h000);
        set_thr();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.chan_sel = 2'd0;  ifb.chan_sel = 2'd0;
        ifa.thresh = '0;      ifb.thresh = '0;
        drive(1'b1, X0 + 1, Y0 + 1, 12'hABC);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifa.pixel_out !== 12'h000) begin errors++; $display("FAIL reset_pixel_out: got %h want 000", ifa.pixel_out); end
        checks++; if (ifa.quad_bits !== '0) begin errors++; $display("FAIL reset_quad_bits: got %h want 0", ifa.quad_bits); end
        checks++; if (ifa.quad_count !== '0) begin errors++; $display("FAIL reset_quad_count: got %h want 0", ifa.quad_count); end
        checks++; if (ifa.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b want 0", ifa.result_valid); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
        drive(1'b0, 0, 0, 12'h000);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int r0, b0;
        logic [4*ND-1:0] all_f;
        logic [3*ND-1:0] all_4;
        all_f = {ND{4'hF}};
        all_4 = {ND{3'd4}};
        for (int q = 0; q < 4; q++) begin thr_a[q] = 100; thr_b[q] = 100; end
        r0 = rv_a; b0 = busy_a;
        run_frame(1, 12'hF00, 2'd0, 1'b0, -1, 1'b0);
        checks++; if (rv_a - r0 != 1) begin errors++; $display("FAIL full_rv_pulses: got %0d want 1", rv_a - r0); end
        checks++; if (busy_a - b0 != ND) begin errors++; $display("FAIL full_busy_cycles: got %0d want %0d", busy_a - b0, ND); end
        checks++; if (ifa.quad_bits !== all_f) begin errors++; $display("FAIL full_bits: got %h want %h", ifa.quad_bits, all_f); end
        checks++; if (ifa.quad_count !== all_4) begin errors++; $display("FAIL full_count: got %h want %h", ifa.quad_count, all_4); end
        checks++; if (pix_bad != 0) begin errors++; $display("FAIL full_pixel_out: got %0d bad want 0", pix_bad); end
    endtask

    task automatic test_zero_thresh();
        for (int q = 0; q < 4; q++) begin thr_a[q] = 0; thr_b[q] = 0; end
        run_frame(1, 12'hF00, 2'd1, 1'b0, -1, 1'b0);
        checks++; if (ifa.quad_bits !== '0) begin errors++; $display("FAIL zero_bits_a: got %h want 0", ifa.quad_bits); end
        checks++; if (ifa.quad_count !== '0) begin errors++; $display("FAIL zero_count_a: got %h want 0", ifa.quad_count); end
        checks++; if (ifb.quad_bits !== '0) begin errors++; $display("FAIL zero_bits_b: got %h want 0", ifb.quad_bits); end
    endtask

    task automatic test_boundary();
        logic [4*ND-1:0] e;
        thr_a = '{14, 1000, 1000, 1000};
        thr_b = '{14, 200, 200, 200};
        run_frame(2, 12'hF00, 2'd0, 1'b0, -1, 1'b0);
        e = 1;
        checks++; if (ifa.quad_bits !== e) begin errors++; $display("FAIL edge_ul14_bits: got %h want %h", ifa.quad_bits, e); end
        e = exp_bits(WB, thr_b);
        checks++; if (ifb.quad_bits !== e) begin errors++; $display("FAIL edge_ul14_bits_b: got %h want %h", ifb.quad_bits, e); end
        thr_a[0] = 15;
        run_frame(2, 12'hF00, 2'd0, 1'b0, -1, 1'b0);
        checks++; if (ifa.quad_bits !== '0) begin errors++; $display("FAIL edge_ul15_bits: got %h want 0", ifa.quad_bits); end
        checks++; if (ifa.quad_count !== '0) begin errors++; $display("FAIL edge_ul15_count: got %h want 0", ifa.quad_count); end
    endtask

    task automatic test_saturation();
        logic [4*ND-1:0] all_f;
        all_f = {ND{4'hF}};
        for (int q = 0; q < 4; q++) begin thr_a[q] = 539; thr_b[q] = 254; end
        run_frame(1, 12'hFFF, 2'd3, 1'b0, -1, 1'b0);
        checks++; if (ifb.quad_bits !== all_f) begin errors++; $display("FAIL sat_254_bits_b: got %h want %h", ifb.quad_bits, all_f); end
        checks++; if (ifa.quad_bits !== all_f) begin errors++; $display("FAIL sat_539_bits_a: got %h want %h", ifa.quad_bits, all_f); end
        for (int q = 0; q < 4; q++) begin thr_a[q] = 540; thr_b[q] = 255; end
        run_frame(1, 12'hFFF, 2'd3, 1'b0, -1, 1'b0);
        checks++; if (ifb.quad_bits !== '0) begin errors++; $display("FAIL sat_255_bits_b: got %h want 0", ifb.quad_bits); end
        checks++; if (ifa.quad_bits !== '0) begin errors++; $display("FAIL sat_540_bits_a: got %h want 0", ifa.quad_bits); end
    endtask

    task automatic test_reset_mid();
        int r0;
        logic [4*ND-1:0] e;
        for (int q = 0; q < 4; q++) begin thr_a[q] = 100; thr_b[q] = 100; end
        run_frame(1, 12'hF00, 2'd0, 1'b0, -1, 1'b0);
        r0 = rv_a;
        run_frame(1, 12'hF00, 2'd0, 1'b0, 5, 1'b0);
        checks++; if (rv_a - r0 != 0) begin errors++; $display("FAIL rstmid_rv_pulses: got %0d want 0", rv_a - r0); end
        checks++; if (ifa.quad_bits !== '0) begin errors++; $display("FAIL rstmid_bits_cleared: got %h want 0", ifa.quad_bits); end
        for (int q = 0; q < 4; q++) begin thr_a[q] = int'($urandom_range(40, 140)); thr_b[q] = thr_a[q]; end
        r0 = rv_a;
        run_frame(0, 12'h000, 2'd2, 1'b0, -1, 1'b0);
        e = exp_bits(WA, thr_a);
        checks++; if (rv_a - r0 != 1) begin errors++; $display("FAIL rstmid_next_rv: got %0d want 1", rv_a - r0); end
        checks++; if (ifa.quad_bits !== e) begin errors++; $display("FAIL rstmid_next_bits: got %h want %h", ifa.quad_bits, e); end
        checks++; if (ifa.quad_count !== exp_count(e)) begin errors++; $display("FAIL rstmid_next_count: got %h want %h", ifa.quad_count, exp_count(e)); end
    endtask

    task automatic test_pix_en_toggle();
        int r0;
        logic [1:0] sel;
        logic [4*ND-1:0] e;
        sel = 2'($urandom_range(0, 2));
        for (int q = 0; q < 4; q++) begin thr_a[q] = int'($urandom_range(40, 140)); thr_b[q] = thr_a[q]; end
        r0 = rv_a;
        run_frame(0, 12'h000, sel, 1'b1, -1, 1'b0);
        e = exp_bits(WA, thr_a);
        checks++; if (ifa.quad_bits !== e) begin errors++; $display("FAIL toggle_bits: got %h want %h", ifa.quad_bits, e); end
        checks++; if (ifa.quad_count !== exp_count(e)) begin errors++; $display("FAIL toggle_count: got %h want %h", ifa.quad_count, exp_count(e)); end
        checks++; if (pix_bad != 0) begin errors++; $display("FAIL toggle_pixel_out: got %0d bad want 0", pix_bad); end
        checks++; if (rv_a - r0 != 1) begin errors++; $display("FAIL toggle_rv: got %0d want 1", rv_a - r0); end
    endtask

    task automatic test_random_frames();
        int r0, rb0;
        logic [1:0] sel;
        logic [4*ND-1:0] ea, eb;
        for (int n = 0; n < 4; n++) begin
            sel = 2'($urandom_range(0, 3));
            for (int q = 0; q < 4; q++) begin
                thr_a[q] = (sel == 2'd3) ? int'($urandom_range(150, 400)) : int'($urandom_range(40, 140));
                thr_b[q] = (sel == 2'd3) ? int'($urandom_range(0, 255))   : int'($urandom_range(40, 140));
            end
            r0 = rv_a; rb0 = rv_b;
            // Alternate frames disturb thresh during evaluation; the latched copy must win.
            run_frame(0, 12'h000, sel, 1'b0, -1, n[0]);
            ea = exp_bits(WA, thr_a);
            eb = exp_bits(WB, thr_b);
            checks++; if (ifa.quad_bits !== ea) begin errors++; $display("FAIL rand%0d_bits_a: got %h want %h", n, ifa.quad_bits, ea); end
            checks++; if (ifa.quad_count !== exp_count(ea)) begin errors++; $display("FAIL rand%0d_count_a: got %h want %h", n, ifa.quad_count, exp_count(ea)); end
            checks++; if (ifb.quad_bits !== eb) begin errors++; $display("FAIL rand%0d_bits_b: got %h want %h", n, ifb.quad_bits, eb); end
            checks++; if (ifb.quad_count !== exp_count(eb)) begin errors++; $display("FAIL rand%0d_count_b: got %h want %h", n, ifb.quad_count, exp_count(eb)); end
            checks++; if (rv_a - r0 != 1 || rv_b - rb0 != 1) begin errors++; $display("FAIL rand%0d_rv: got %0d/%0d want 1/1", n, rv_a - r0, rv_b - rb0); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_zero_thresh();
        test_boundary();
        test_saturation();
        test_reset_mid();
        test_pix_en_toggle();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
